// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through stream FIFO with occupancy count,
// full/empty/almost_full flags and a high-water mark. flush clears the
// queue synchronously; rst_n clears it asynchronously. Payload storage is
// never cleared; m_data is forced to zero whenever the queue is empty.
module stream_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       s_valid,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       s_ready,
  output logic                       m_valid,
  output logic [DATA_W-1:0]          m_data,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] high_water
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] hw_q, hw_d;

  logic push;
  logic pop;

  // Flags come from registered occupancy only, so there is no path from
  // s_valid or m_ready to s_ready or m_valid.
  assign full        = (count_q == DEPTH_C);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AF_C);
  assign s_ready     = !full;
  assign m_valid     = !empty;
  assign count       = count_q;
  assign high_water  = hw_q;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  // Head entry falls straight through from storage; zero when nothing is queued.
  assign m_data = m_valid ? mem_q[rd_ptr_q] : '0;

  // Next-state for pointers, occupancy and high-water; flush wins over traffic.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hw_d     = hw_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      hw_d     = '0;
    end else begin
      // Pointer width equals log2(DEPTH), so increments wrap naturally.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (count_d > hw_q) hw_d = count_d;
    end
  end

  // Control state register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hw_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hw_q     <= hw_d;
    end
  end

  // Payload storage: written on an accepted push unless flushed, never cleared.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed plus randomized stimulus against a queue-based
// reference model of the FIFO (DEPTH=8, DATA_W=8, AF_LEVEL=7).
module tb_stream_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m_ready = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [CW-1:0] high_water;

  int total = 0;
  int bad   = 0;

  // Reference model: ordered list of stored words plus the peak occupancy.
  logic [DW-1:0] q[$];
  int            hw = 0;

  stream_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(DEPTH-1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .high_water  (high_water)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    logic [DW-1:0] head;
    n = q.size();
    head = (n > 0) ? q[0] : '0;
    chk({tag, ".count"},       64'(count),       64'(n));
    chk({tag, ".empty"},       64'(empty),       64'(n == 0));
    chk({tag, ".full"},        64'(full),        64'(n == DEPTH));
    chk({tag, ".almost_full"}, 64'(almost_full), 64'(n >= DEPTH-1));
    chk({tag, ".m_valid"},     64'(m_valid),     64'(n != 0));
    chk({tag, ".s_ready"},     64'(s_ready),     64'(n != DEPTH));
    chk({tag, ".m_data"},      64'(m_data),      64'(head));
    chk({tag, ".high_water"},  64'(high_water),  64'(hw));
  endtask

  // One clock cycle: drive inputs just after a falling edge, update the model
  // at the rising edge, and compare all outputs on the next falling edge.
  task automatic cycle(input string tag, input logic sv, input logic [DW-1:0] sd,
                       input logic mr, input logic fl);
    bit do_push;
    bit do_pop;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    do_push = sv && (q.size() < DEPTH);
    do_pop  = mr && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
      hw = 0;
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(sd);
      if (q.size() > hw) hw = q.size();
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    check_state(tag);
    $display("cyc t=%0t %s sv=%0b sd=%02h mr=%0b fl=%0b -> count=%0d m_data=%02h hw=%0d",
             $time, tag, sv, sd, mr, fl, count, m_data, high_water);
  endtask

  initial begin
    // Asynchronous reset assertion before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check_state("rst_async");
    @(negedge clk);
    check_state("rst_hold");
    rst_n = 1'b1;

    // Ordering after reset: three pushes, then drain.
    cycle("ord_push", 1'b1, 8'h11, 1'b0, 1'b0);
    cycle("ord_push", 1'b1, 8'h22, 1'b0, 1'b0);
    cycle("ord_push", 1'b1, 8'h33, 1'b0, 1'b0);
    chk("ord_head0", 64'(m_data), 64'h11);
    cycle("ord_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("ord_head1", 64'(m_data), 64'h22);
    cycle("ord_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("ord_head2", 64'(m_data), 64'h33);
    cycle("ord_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("ord_empty", 64'(empty), 64'd1);
    cycle("ord_idle", 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to DEPTH, then offer a ninth word that must be refused.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_hw", 64'(high_water), 64'(DEPTH));
    cycle("fill_ninth", 1'b1, 8'hEE, 1'b0, 1'b0);

    // Full with push and pop together: only the pop happens.
    cycle("full_both", 1'b1, 8'hC1, 1'b1, 1'b0);
    chk("full_both_cnt", 64'(count), 64'(DEPTH-1));
    cycle("both_at7", 1'b1, 8'hC2, 1'b1, 1'b0);
    chk("both_at7_cnt", 64'(count), 64'(DEPTH-1));

    // Drain to 3, then 20 push/pop pairs across pointer wrap.
    while (q.size() > 3) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle("wrap", 1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("wrap_cnt", 64'(count), 64'd3);

    // Flush at count 5 together with a push and a pop.
    cycle("pre_flush", 1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle("pre_flush", 1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle("flush", 1'b1, 8'h5F, 1'b1, 1'b1);
    chk("flush_hw", 64'(high_water), 64'd0);
    cycle("post_flush", 1'b1, 8'h61, 1'b0, 1'b0);
    cycle("post_flush", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset between edges at count 4.
    for (int i = 0; i < 4; i++) cycle("pre_rst", 1'b1, 8'($urandom), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    q.delete();
    hw = 0;
    #1;
    check_state("rst_mid");
    @(negedge clk);
    check_state("rst_mid_hold");
    rst_n = 1'b1;
    cycle("rst_push", 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("rst_push_data", 64'(m_data), 64'hA5);
    cycle("rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with varying bias so both full and empty are visited.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = (i / 50) % 2;
      cycle("rand",
            ($urandom_range(0, 3) != 0) ^ (bias == 1 && $urandom_range(0, 1) == 0),
            8'($urandom),
            ($urandom_range(0, 3) == 0) ^ (bias == 1),
            ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 8: number of entries; SHALL be a power of two and at least 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-1: almost_full threshold; legal range 1..DEPTH.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous clear of all queued data.
REQ-007 s_valid  input  1  upstream presents a word.
REQ-008 s_data  input  DATA_W  upstream payload.
REQ-009 s_ready  output  1  FIFO accepts a word this cycle.
REQ-010 m_valid  output  1  a word is available downstream.
REQ-011 m_data  output  DATA_W  head-of-queue payload.
REQ-012 m_ready  input  1  downstream consumes the head word.
REQ-013 count  output  $clog2(DEPTH+1)  number of stored words.
REQ-014 full, empty, almost_full  output  1 each  status flags.
REQ-015 high_water  output  $clog2(DEPTH+1)  maximum count reached since reset or flush.

Function
REQ-016 Push: a word is written when s_valid && s_ready at a rising edge.
REQ-017 Pop: the head word is removed when m_valid && m_ready at a rising edge.
REQ-018 s_ready SHALL equal !full; m_valid SHALL equal !empty; both are derived from registered state only, with no combinational path from s_valid or m_ready.
REQ-019 Storage is first-word-fall-through: m_data SHALL show the head entry combinationally from the memory at rd_ptr whenever m_valid=1.
REQ-020 m_data SHALL be all-zero whenever m_valid=0.
REQ-021 Latency: a word pushed into an empty FIFO SHALL appear with m_valid=1 on the cycle after the push edge; there is no same-cycle bypass.
REQ-022 Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-023 count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
REQ-024 Simultaneous push and pop with 0<count<DEPTH: both SHALL occur, and order SHALL be preserved.
REQ-025 When full, no push occurs because s_ready=0, even if a pop happens in the same cycle.
REQ-026 When empty, no pop occurs, and a push in that cycle SHALL still succeed.
REQ-027 Flags: full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_LEVEL).
REQ-028 high_water SHALL update to the next count whenever the next count exceeds the current high_water.
REQ-029 flush=1 at an edge SHALL set both pointers, count and high_water to 0.
REQ-030 flush SHALL take priority over any push or pop in the same cycle, and that push or pop is discarded.
REQ-031 The memory array is not reset or cleared; its contents are unobservable while empty.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for clk, force wr_ptr=0, rd_ptr=0, count=0 and high_water=0.
REQ-033 While rst_n=0, outputs SHALL be: empty=1, full=0, almost_full=0, m_valid=0, s_ready=1 and m_data=0.
REQ-034 Reset asserted mid-transfer SHALL discard all stored words, and the first pop after release SHALL return only data pushed after release.
REQ-035 Deassertion of rst_n is synchronised to clk by the integrating level.
REQ-036 The first push SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-037 Order after reset: push 0x11, 0x22, 0x33 with m_ready=0, then hold m_ready=1 -> m_data = 0x11, 0x22, 0x33 on consecutive cycles, then empty=1 and m_data=0.
REQ-038 Fill (DEPTH=8): push 8 words -> full=1 and s_ready=0 after the 8th edge; almost_full=1 from count=7; a 9th s_valid is not accepted; high_water=8.
REQ-039 Full with simultaneous traffic: when full, assert s_valid and m_ready together -> one pop only, count=7; on the next cycle push and pop together -> count stays 7.
REQ-040 Wrap: run 20 push/pop pairs at count=3 -> the data sequence is intact across pointer wrap, and count stays 3 throughout.
REQ-041 Flush: at count=5, assert flush together with s_valid and m_ready -> next cycle count=0, empty=1 and high_water=0, and the flushed-cycle data never appears.
REQ-042 Async reset: drop rst_n between clk edges at count=4 -> m_valid=0 and count=0 before the next edge; after release, pushing 0xA5 -> m_data=0xA5 one cycle later.
